// File: rtl/risc_spm_pkg.sv
// Shared encodings for the RISC_SPM control unit: opcodes, FSM states,
// bus mux select codes and the 2-to-4 register decode helper.
package risc_spm_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_NOT  = 4'd4,
      OP_RD   = 4'd5,
      OP_WR   = 4'd6,
      OP_BR   = 4'd7,
      OP_BRZ  = 4'd8,
      OP_HALT = 4'd15
   } opcode_t;

   typedef enum logic [3:0] {
      S_idle = 4'd0,
      S_fet1 = 4'd1,
      S_fet2 = 4'd2,
      S_dec  = 4'd3,
      S_ex1  = 4'd4,
      S_rd1  = 4'd5,
      S_rd2  = 4'd6,
      S_wr1  = 4'd7,
      S_wr2  = 4'd8,
      S_br1  = 4'd9,
      S_br2  = 4'd10,
      S_halt = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      SEL1_R0 = 3'd0,
      SEL1_R1 = 3'd1,
      SEL1_R2 = 3'd2,
      SEL1_R3 = 3'd3,
      SEL1_PC = 3'd4
   } sel1_t;

   typedef enum logic [1:0] {
      SEL2_ALU  = 2'd0,
      SEL2_BUS1 = 2'd1,
      SEL2_MEM  = 2'd2
   } sel2_t;

   // One-hot register select from a 2-bit src/dest field
   function automatic logic [3:0] reg_decode(input logic [1:0] idx);
      reg_decode = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/risc_spm_control_unit_if.sv
// Control-unit <-> datapath signal bundle. master = control unit side,
// slave = datapath side.
interface risc_spm_control_unit_if;
   logic [7:0] instruction;
   logic       Zflag;
   logic       run;
   logic       Load_R0;
   logic       Load_R1;
   logic       Load_R2;
   logic       Load_R3;
   logic       Load_PC;
   logic       Inc_PC;
   logic       Load_IR;
   logic       Load_Add_R;
   logic       Load_Reg_Y;
   logic       Load_Reg_Z;
   logic [2:0] Sel_Bus_1_Mux;
   logic [1:0] Sel_Bus_2_Mux;
   logic       write;
   logic       halted;

   modport master (
      input  instruction, Zflag, run,
      output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
             Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
             write, halted
   );

   modport slave (
      output instruction, Zflag, run,
      input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
             Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux,
             write, halted
   );
endinterface

// File: rtl/risc_spm_control_unit.sv
// Multi-cycle Mealy control unit for the RISC_SPM processor: sequences
// fetch, decode, execute, memory read/write and branch, one instruction
// at a time. Only the state register is clocked.
module risc_spm_control_unit
   import risc_spm_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   risc_spm_control_unit_if.master bus
);

   state_t     state_q, state_d;
   opcode_t    op;
   logic [1:0] src, dest;

   logic [3:0] load_r;
   logic       ld_pc, inc_pc, ld_ir, ld_ar, ld_y, ld_z, wr, halt;
   sel1_t      sel1;
   sel2_t      sel2;

   assign op   = opcode_t'(bus.instruction[7:4]);
   assign src  = bus.instruction[3:2];
   assign dest = bus.instruction[1:0];

   // State register; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_idle;
      else      state_q <= state_d;
   end

   // Next state and Mealy outputs from state, opcode fields and Zflag
   always_comb begin
      state_d = state_q;
      load_r  = '0;
      ld_pc   = 1'b0;
      inc_pc  = 1'b0;
      ld_ir   = 1'b0;
      ld_ar   = 1'b0;
      ld_y    = 1'b0;
      ld_z    = 1'b0;
      wr      = 1'b0;
      halt    = 1'b0;
      sel1    = SEL1_R0;
      sel2    = SEL2_ALU;
      case (state_q)
         S_idle: if (bus.run) state_d = S_fet1;
         S_fet1: begin
            sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_ar = 1'b1;
            state_d = S_fet2;
         end
         S_fet2: begin
            sel2 = SEL2_MEM; ld_ir = 1'b1; inc_pc = 1'b1;
            state_d = S_dec;
         end
         S_dec: begin
            case (op)
               OP_NOP: state_d = S_fet1;
               OP_ADD, OP_SUB, OP_AND: begin
                  sel1 = sel1_t'({1'b0, src}); sel2 = SEL2_BUS1; ld_y = 1'b1;
                  state_d = S_ex1;
               end
               OP_NOT: begin
                  sel1 = sel1_t'({1'b0, src}); sel2 = SEL2_ALU;
                  ld_z = 1'b1; load_r = reg_decode(dest);
                  state_d = S_fet1;
               end
               OP_RD, OP_WR, OP_BR: begin
                  sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_ar = 1'b1;
                  state_d = (op == OP_RD) ? S_rd1 : (op == OP_WR) ? S_wr1 : S_br1;
               end
               OP_BRZ: begin
                  if (bus.Zflag) begin
                     sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_ar = 1'b1;
                     state_d = S_br1;
                  end else begin
                     inc_pc  = 1'b1;
                     state_d = S_fet1;
                  end
               end
               OP_HALT: state_d = S_halt;
               default: state_d = ILLEGAL_HALT ? S_halt : S_fet1;
            endcase
         end
         S_ex1: begin
            sel1 = sel1_t'({1'b0, dest}); sel2 = SEL2_ALU;
            ld_z = 1'b1; load_r = reg_decode(dest);
            state_d = S_fet1;
         end
         S_rd1: begin
            sel2 = SEL2_MEM; ld_ar = 1'b1; inc_pc = 1'b1;
            state_d = S_rd2;
         end
         S_rd2: begin
            sel2 = SEL2_MEM; load_r = reg_decode(dest);
            state_d = S_fet1;
         end
         S_wr1: begin
            sel2 = SEL2_MEM; ld_ar = 1'b1; inc_pc = 1'b1;
            state_d = S_wr2;
         end
         S_wr2: begin
            sel1 = sel1_t'({1'b0, src}); wr = 1'b1;
            state_d = S_fet1;
         end
         S_br1: begin
            sel2 = SEL2_MEM; ld_ar = 1'b1;
            state_d = S_br2;
         end
         S_br2: begin
            sel2 = SEL2_MEM; ld_pc = 1'b1;
            state_d = S_fet1;
         end
         S_halt: halt = 1'b1;
         default: state_d = S_idle;
      endcase
   end

   assign bus.Load_R0       = load_r[0];
   assign bus.Load_R1       = load_r[1];
   assign bus.Load_R2       = load_r[2];
   assign bus.Load_R3       = load_r[3];
   assign bus.Load_PC       = ld_pc;
   assign bus.Inc_PC        = inc_pc;
   assign bus.Load_IR       = ld_ir;
   assign bus.Load_Add_R    = ld_ar;
   assign bus.Load_Reg_Y    = ld_y;
   assign bus.Load_Reg_Z    = ld_z;
   assign bus.Sel_Bus_1_Mux = sel1;
   assign bus.Sel_Bus_2_Mux = sel2;
   assign bus.write         = wr;
   assign bus.halted        = halt;

endmodule

// File: tb/tb_risc_spm_control_unit.sv
// Directed self-checking bench for risc_spm_control_unit. Two instances:
// dut halts on illegal opcodes, dut_nop treats them as NOP.
module tb_risc_spm_control_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   risc_spm_control_unit_if cu ();
   risc_spm_control_unit_if cun ();

   risc_spm_control_unit #(.ILLEGAL_HALT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (cu)
   );

   risc_spm_control_unit #(.ILLEGAL_HALT(1'b0)) dut_nop (
      .clk (clk),
      .rst (rst),
      .bus (cun)
   );

   // Output word: {R3,R2,R1,R0, PC, Inc, IR, AddR, Y, Z, Sel1[2:0], Sel2[1:0], write, halted}
   function automatic logic [16:0] mk(input logic [3:0] ldr, input logic pc, input logic inc,
                                      input logic ir, input logic ar, input logic y, input logic z,
                                      input logic [2:0] s1, input logic [1:0] s2,
                                      input logic w, input logic h);
      mk = {ldr, pc, inc, ir, ar, y, z, s1, s2, w, h};
   endfunction

   function automatic logic [16:0] obs();
      obs = {cu.Load_R3, cu.Load_R2, cu.Load_R1, cu.Load_R0, cu.Load_PC, cu.Inc_PC,
             cu.Load_IR, cu.Load_Add_R, cu.Load_Reg_Y, cu.Load_Reg_Z,
             cu.Sel_Bus_1_Mux, cu.Sel_Bus_2_Mux, cu.write, cu.halted};
   endfunction

   function automatic logic [16:0] obs_n();
      obs_n = {cun.Load_R3, cun.Load_R2, cun.Load_R1, cun.Load_R0, cun.Load_PC, cun.Inc_PC,
               cun.Load_IR, cun.Load_Add_R, cun.Load_Reg_Y, cun.Load_Reg_Z,
               cun.Sel_Bus_1_Mux, cun.Sel_Bus_2_Mux, cun.write, cun.halted};
   endfunction

   localparam logic [16:0] ZERO_W = 17'd0;
   localparam logic [16:0] FET1_W = mk(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
   localparam logic [16:0] FET2_W = mk(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0);
   localparam logic [16:0] MEM1_W = mk(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0);
   localparam logic [16:0] BR1_W  = mk(4'b0000, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0);
   localparam logic [16:0] BR2_W  = mk(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0);
   localparam logic [16:0] HALT_W = mk(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [7:0] ins, input logic z, input logic r);
      cu.instruction  = ins; cu.Zflag  = z; cu.run  = r;
      cun.instruction = ins; cun.Zflag = z; cun.run = r;
   endtask

   task automatic test_reset();
      set_in(8'h00, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== ZERO_W) $display("FAIL reset_asserted: got %h want %h", obs(), ZERO_W);
      else passes++;
      step();
      #3 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (obs() !== ZERO_W) $display("FAIL idle_run0 cyc%0d: got %h want %h", i, obs(), ZERO_W);
         else passes++;
      end
      set_in(8'h00, 1'b0, 1'b1);
      step();
      set_in(8'h00, 1'b0, 1'b0);
      checks++;
      if (obs() !== FET1_W) $display("FAIL start_fet1: got %h want %h", obs(), FET1_W);
      else passes++;
   endtask

   task automatic test_alu();
      logic [16:0] e_add [5];
      logic [16:0] e_not [4];
      e_add[0] = FET1_W;
      e_add[1] = FET2_W;
      e_add[2] = mk(4'b0000, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 0);
      e_add[3] = mk(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0);
      e_add[4] = FET1_W;
      set_in(8'h16, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e_add[i]) $display("FAIL add_r1_r2 cyc%0d: got %h want %h", i, obs(), e_add[i]);
         else passes++;
      end
      e_not[0] = FET1_W;
      e_not[1] = FET2_W;
      e_not[2] = mk(4'b0010, 0, 0, 0, 0, 0, 1, 3'd3, 2'd0, 0, 0);
      e_not[3] = FET1_W;
      set_in(8'h4D, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e_not[i]) $display("FAIL not_r3_r1 cyc%0d: got %h want %h", i, obs(), e_not[i]);
         else passes++;
      end
   endtask

   task automatic test_rd();
      logic [16:0] e [6];
      e[0] = FET1_W; e[1] = FET2_W; e[2] = FET1_W; e[3] = MEM1_W;
      e[4] = mk(4'b1000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0);
      e[5] = FET1_W;
      set_in(8'h53, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) $display("FAIL rd_r3 cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
   endtask

   task automatic test_wr();
      logic [16:0] e [6];
      e[0] = FET1_W; e[1] = FET2_W; e[2] = FET1_W; e[3] = MEM1_W;
      e[4] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 3'd1, 2'd0, 1, 0);
      e[5] = FET1_W;
      set_in(8'h64, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) $display("FAIL wr_r1 cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
   endtask

   task automatic test_branch();
      logic [16:0] e [6];
      logic [16:0] n [4];
      e[0] = FET1_W; e[1] = FET2_W; e[2] = FET1_W; e[3] = BR1_W; e[4] = BR2_W; e[5] = FET1_W;
      set_in(8'h70, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) $display("FAIL br cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
      set_in(8'h80, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) $display("FAIL brz_taken cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
      n[0] = FET1_W; n[1] = FET2_W;
      n[2] = mk(4'b0000, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0);
      n[3] = FET1_W;
      set_in(8'h80, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== n[i]) $display("FAIL brz_not_taken cyc%0d: got %h want %h", i, obs(), n[i]);
         else passes++;
      end
   endtask

   task automatic test_nop_illegal();
      logic [16:0] e [4];
      e[0] = FET1_W; e[1] = FET2_W; e[2] = ZERO_W; e[3] = FET1_W;
      set_in(8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) $display("FAIL nop cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
      set_in(8'h90, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         checks++;
         if (obs_n() !== e[i]) $display("FAIL illegal_as_nop cyc%0d: got %h want %h", i, obs_n(), e[i]);
         else passes++;
         checks++;
         if (obs() !== e[i]) $display("FAIL illegal_halt_pre cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
      step();
      checks++;
      if (obs_n() !== FET1_W) $display("FAIL illegal_as_nop_ret: got %h want %h", obs_n(), FET1_W);
      else passes++;
      checks++;
      if (obs() !== HALT_W) $display("FAIL illegal_halts: got %h want %h", obs(), HALT_W);
      else passes++;
   endtask

   task automatic test_halt();
      logic [16:0] e [3];
      set_in(8'h00, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      set_in(8'h00, 1'b0, 1'b1);
      step();
      e[0] = FET1_W; e[1] = FET2_W; e[2] = ZERO_W;
      set_in(8'hF0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) $display("FAIL halt_pre cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
      for (int i = 0; i < 10; i++) begin
         set_in(8'hF0, 1'b0, i[0]);
         step();
         checks++;
         if (obs() !== HALT_W) $display("FAIL halt_hold cyc%0d: got %h want %h", i, obs(), HALT_W);
         else passes++;
      end
   endtask

   task automatic test_reset_mid_rd();
      logic [16:0] e [4];
      set_in(8'h00, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      set_in(8'h00, 1'b0, 1'b1);
      step();
      e[0] = FET1_W; e[1] = FET2_W; e[2] = FET1_W; e[3] = MEM1_W;
      set_in(8'h53, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) $display("FAIL midrst_pre cyc%0d: got %h want %h", i, obs(), e[i]);
         else passes++;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== ZERO_W) $display("FAIL midrst_async: got %h want %h", obs(), ZERO_W);
      else passes++;
      #2 rst = 1'b1;
      step();
      checks++;
      if (obs() !== ZERO_W) $display("FAIL midrst_idle: got %h want %h", obs(), ZERO_W);
      else passes++;
      set_in(8'h53, 1'b0, 1'b1);
      step();
      checks++;
      if (obs() !== FET1_W) $display("FAIL midrst_restart: got %h want %h", obs(), FET1_W);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_rd();
      test_wr();
      test_branch();
      test_nop_illegal();
      test_halt();
      test_reset_mid_rd();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
